// File: rtl/uart_rx.sv
// 8N1 serial receiver with 2-flop input synchronizer and one-cycle result strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits (8E1).
module uart_rx #(
  parameter int clocks_per_bit = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int TICK_W = $clog2(clocks_per_bit);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'((clocks_per_bit - 1) / 2);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(clocks_per_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              rx_q, rx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              tick_zero;

`ifdef UART_RX_PARITY_EN
  logic              parity_err_q, parity_err_d;
  logic              par_bad_q, par_bad_d;
`endif

  assign tick_zero = (tick_q == '0);

  always_comb begin
    sync1_d     = ser_rx;
    rx_d        = sync1_q;
    state_d     = state_q;
    tick_d      = tick_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif

    // Bit-timing counter runs only while a sample point is pending
    if (state_q != S_IDLE && state_q != S_BREAK && !tick_zero) begin
      tick_d = tick_q - TICK_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_q) begin
          state_d   = S_START;
          tick_d    = TICK_HALF;
          bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (tick_zero) begin
          if (!rx_q) begin
            state_d = S_DATA;
            tick_d  = TICK_FULL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_zero) begin
          shreg_d   = {rx_q, shreg_q[7:1]};
          tick_d    = TICK_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_zero) begin
          par_bad_d = rx_q ^ (^shreg_q);
          tick_d    = TICK_FULL;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed
        if (tick_zero) begin
          if (rx_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              out_valid_d = 1'b1;
              out_data_d  = shreg_q;
            end
`else
            out_valid_d = 1'b1;
            out_data_d  = shreg_q;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      rx_q        <= 1'b1;
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_q        <= rx_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames plus hand-written corner sequences,
// with a strobe scoreboard fed by the stimulus side.
module tb_uart_rx;

  localparam int CPB = 3;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_rx;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [1:0] kind;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  vec_t       vecs[6];
  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.clocks_per_bit(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_rx     (ser_rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
    if (kind == K_VALID) last_good = data;
  endtask

  task automatic send_bit(input logic b);
    ser_rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) send_bit(1'b1);
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    int   n;
    logic [1:0] k;
    exp_t e;
    if (rst_n === 1'b1) begin
      n = int'(out_valid) + int'(frame_err) + int'(parity_err);
      if (n > 1) begin
        check("strobe_overlap", 32'(n), 32'd1);
      end else if (n == 1) begin
        k = out_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
        if (sb.size() == 0) begin
          check("unexpected_strobe_kind", 32'(k), 32'hFF);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", 32'(k), 32'(e.kind));
          if (e.kind == K_VALID) check("out_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    logic seen;

    vecs[0] = '{8'h48, 1'b1, K_VALID, 8'h48};
    vecs[1] = '{8'h00, 1'b1, K_VALID, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, K_VALID, 8'hFF};
    vecs[3] = '{8'hA5, 1'b1, K_VALID, 8'hA5};
    vecs[4] = '{8'h5A, 1'b0, K_FERR,  8'h00};
    vecs[5] = '{8'h81, 1'b1, K_VALID, 8'h81};

    rst_n  = 1'b0;
    ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_data",   32'(out_data),   32'h0);
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    rst_n = 1'b1;
    idle(4);

    for (int v = 0; v < 6; v++) begin
      expect_ev(vecs[v].kind, vecs[v].exp_data);
      send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop);
      idle(2 * CPB);
    end
    check("held_after_table", 32'(out_data), 32'(last_good));

    // Back-to-back frames, single stop bit each
    expect_ev(K_VALID, 8'h48);
    expect_ev(K_VALID, 8'h69);
    send_frame(8'h48, ^8'h48, 1'b1);
    send_frame(8'h69, ^8'h69, 1'b1);
    idle(3 * CPB);
    check("b2b_data", 32'(out_data), 32'h69);

    // One-clock glitch: busy pulses, no strobe
    seen   = 1'b0;
    ser_rx = 1'b0;
    @(negedge clk);
    ser_rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen), 32'h1);
    check("glitch_back_idle", 32'(busy), 32'h0);

    // Bad stop bit then line held low: single frame_err, no bytes
    expect_ev(K_FERR, 8'h00);
    send_frame(8'h55, ^8'h55, 1'b0);
    ser_rx = 1'b0;
    repeat (40) @(negedge clk);
    check("break_busy", 32'(busy), 32'h1);
    check("ferr_data_held", 32'(out_data), 32'(last_good));
    idle(3 * CPB);
    check("break_released", 32'(busy), 32'h0);
    expect_ev(K_VALID, 8'hA3);
    send_frame(8'hA3, ^8'hA3, 1'b1);
    idle(3 * CPB);
    check("after_break_data", 32'(out_data), 32'hA3);

    // Async reset mid-byte of 0x7E
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'(8'h7E >> i));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_data",  32'(out_data),  32'h0);
    check("midrst_busy",      32'(busy),      32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    last_good = 8'h00;
    @(negedge clk);
    ser_rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    expect_ev(K_VALID, 8'h31);
    send_frame(8'h31, ^8'h31, 1'b1);
    idle(3 * CPB);
    check("post_rst_data", 32'(out_data), 32'h31);

`ifdef UART_RX_PARITY_EN
    expect_ev(K_VALID, 8'h48);
    send_frame(8'h48, 1'b0, 1'b1);
    idle(3 * CPB);
    expect_ev(K_PERR, 8'h00);
    send_frame(8'h48, 1'b1, 1'b1);
    idle(3 * CPB);
    check("perr_data_held", 32'(out_data), 32'h48);
`endif

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", 32'(sb.size()), 32'h0);
    check("final_data", 32'(out_data), 32'(last_good));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
